// File: rtl/pri_dec_3x8_pulse_if.sv
// Handshake and output bundle for the pulsed 3-to-8 decoder.
// The master side supplies enable and indices; the slave side is the decoder.
interface pri_dec_3x8_pulse_if;
  logic       en;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_idx;
  logic [7:0] y;
  logic       done;
  logic       busy;

  modport master (
    output en,
    output in_valid,
    output in_idx,
    input  in_ready,
    input  y,
    input  done,
    input  busy
  );

  modport slave (
    input  en,
    input  in_valid,
    input  in_idx,
    output in_ready,
    output y,
    output done,
    output busy
  );
endinterface

// File: rtl/pri_dec_3x8_pulse.sv
// Registered 3-to-8 one-hot decoder that holds each line for PULSE_LEN cycles,
// inserts GAP idle cycles between pulses and queues one index while busy.
module pri_dec_3x8_pulse #(
  parameter int PULSE_LEN = 4,
  parameter int GAP       = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  pri_dec_3x8_pulse_if.slave  bus
);

  localparam int MAX_LEN = (PULSE_LEN > GAP) ? PULSE_LEN : GAP;
  localparam int CNT_W   = $clog2(MAX_LEN) + 1;
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       y_q, y_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_v_q, pend_v_d;
  logic [2:0]       pend_idx_q, pend_idx_d;

  logic             xfer;
  logic             next_v;
  logic [2:0]       next_idx;

  // in_ready is held low during reset so nothing is offered an accept it cannot get.
  assign bus.in_ready = rst_n && bus.en && !pend_v_q;
  assign xfer         = bus.in_valid && bus.in_ready;

  // The queued entry always wins; a live transfer is only used when the slot is empty.
  assign next_v   = pend_v_q || xfer;
  assign next_idx = pend_v_q ? pend_idx_q : bus.in_idx;

  always_comb begin
    state_d    = state_q;
    y_d        = y_q;
    done_d     = 1'b0;
    cnt_d      = cnt_q;
    pend_v_d   = pend_v_q;
    pend_idx_d = pend_idx_q;

    if (!bus.en) begin
      state_d  = S_IDLE;
      y_d      = 8'h00;
      cnt_d    = '0;
      pend_v_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (xfer) begin
            y_d     = 8'b1 << bus.in_idx;
            cnt_d   = PULSE_LOAD;
            state_d = S_ACTIVE;
          end
        end

        S_ACTIVE: begin
          if (xfer) begin
            pend_v_d   = 1'b1;
            pend_idx_d = bus.in_idx;
          end
          if (cnt_q == '0) begin
            done_d = 1'b1;
            if (GAP > 0) begin
              y_d     = 8'h00;
              cnt_d   = GAP_LOAD;
              state_d = S_GAP;
            end else if (next_v) begin
              y_d      = 8'b1 << next_idx;
              pend_v_d = 1'b0;
              cnt_d    = PULSE_LOAD;
            end else begin
              y_d     = 8'h00;
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end

        S_GAP: begin
          if (xfer) begin
            pend_v_d   = 1'b1;
            pend_idx_d = bus.in_idx;
          end
          if (cnt_q == '0) begin
            if (next_v) begin
              y_d      = 8'b1 << next_idx;
              pend_v_d = 1'b0;
              cnt_d    = PULSE_LOAD;
              state_d  = S_ACTIVE;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end

        default: begin
          state_d  = S_IDLE;
          y_d      = 8'h00;
          cnt_d    = '0;
          pend_v_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      y_q        <= 8'h00;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      pend_v_q   <= 1'b0;
      pend_idx_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      y_q        <= y_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      pend_v_q   <= pend_v_d;
      pend_idx_q <= pend_idx_d;
    end
  end

  assign bus.y    = y_q;
  assign bus.done = done_q;
  assign bus.busy = (state_q != S_IDLE) || pend_v_q;

endmodule

// File: tb/tb_pri_dec_3x8_pulse.sv
// Bench for pri_dec_3x8_pulse: two instances (GAP=1 and GAP=0) checked against a
// schedule model that places each accepted index on a timeline of pulse windows.
module tb_pri_dec_3x8_pulse;

  localparam int PL = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en_tb = 1'b0;
  logic       valid_tb = 1'b0;
  logic [2:0] idx_tb = 3'd0;
  logic       sel = 1'b0;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  pri_dec_3x8_pulse_if if0 ();
  pri_dec_3x8_pulse_if if1 ();

  assign if0.en       = en_tb && !sel;
  assign if0.in_valid = valid_tb && !sel;
  assign if0.in_idx   = idx_tb;
  assign if1.en       = en_tb && sel;
  assign if1.in_valid = valid_tb && sel;
  assign if1.in_idx   = idx_tb;

  pri_dec_3x8_pulse #(.PULSE_LEN(PL), .GAP(1)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  pri_dec_3x8_pulse #(.PULSE_LEN(PL), .GAP(0)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  logic [7:0] act_y;
  logic       act_done, act_busy, act_ready;
  assign act_y     = sel ? if1.y        : if0.y;
  assign act_done  = sel ? if1.done     : if0.done;
  assign act_busy  = sel ? if1.busy     : if0.busy;
  assign act_ready = sel ? if1.in_ready : if0.in_ready;

  // Model: every accepted index is a record (accept edge k, start edge s).
  // Pulse occupies edges s..s+PL-1, done follows at s+PL, gap ends at s+PL+GAP.
  typedef struct {
    int idx;
    int k;
    int s;
  } item_t;

  item_t      q[$];
  int         e = 0;
  int         gapm = 1;
  logic [7:0] exp_y;
  logic       exp_done, exp_busy;

  function automatic logic model_ready();
    logic pend;
    pend = 1'b0;
    foreach (q[i]) if (q[i].k <= e && e < q[i].s) pend = 1'b1;
    return rst_n && en_tb && !pend;
  endfunction

  function automatic void model_outputs();
    exp_y    = 8'h00;
    exp_done = 1'b0;
    exp_busy = 1'b0;
    foreach (q[i]) begin
      if (q[i].s <= e && e < q[i].s + PL) exp_y = 8'b1 << q[i].idx;
      if (q[i].s + PL == e) exp_done = 1'b1;
      if (q[i].k <= e && e < q[i].s + PL + gapm) exp_busy = 1'b1;
    end
  endfunction

  task automatic tick(output logic xfer);
    item_t it;
    xfer = valid_tb && model_ready();
    @(posedge clk);
    e = e + 1;
    if (!en_tb || !rst_n) begin
      q.delete();
    end else if (xfer) begin
      it.idx = int'(idx_tb);
      it.k   = e;
      it.s   = e;
      if (q.size() > 0 && q[$].s + PL + gapm > it.s) it.s = q[$].s + PL + gapm;
      q.push_back(it);
    end
    while (q.size() > 0 && q[0].s + PL + gapm < e) void'(q.pop_front());
    #1;
    model_outputs();
  endtask

  task automatic select_dut(input logic which);
    logic x;
    en_tb    = 1'b0;
    valid_tb = 1'b0;
    tick(x);
    sel  = which;
    gapm = which ? 0 : 1;
    tick(x);
    en_tb = 1'b1;
  endtask

  task automatic test_reset();
    logic x;
    en_tb = 1'b1;
    #3;
    checks++; if (act_y !== 8'h00)  begin fails++; $display("[TB] FAIL reset.y got %h want 00", act_y); end
    checks++; if (act_done !== 1'b0) begin fails++; $display("[TB] FAIL reset.done got %b want 0", act_done); end
    checks++; if (act_busy !== 1'b0) begin fails++; $display("[TB] FAIL reset.busy got %b want 0", act_busy); end
    checks++; if (act_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset.ready got %b want 0", act_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(x);
    checks++; if (act_y !== 8'h00)  begin fails++; $display("[TB] FAIL reset.release_y got %h want 00", act_y); end
    checks++; if (act_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset.release_ready got %b want 1", act_ready); end
    valid_tb = 1'b1; idx_tb = 3'd3;
    tick(x);
    valid_tb = 1'b0;
    tick(x);
    checks++; if (act_y !== exp_y) begin fails++; $display("[TB] FAIL reset.running_y got %h want %h", act_y, exp_y); end
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    checks++; if (act_y !== 8'h00)  begin fails++; $display("[TB] FAIL reset.mid_y got %h want 00", act_y); end
    checks++; if (act_done !== 1'b0) begin fails++; $display("[TB] FAIL reset.mid_done got %b want 0", act_done); end
    checks++; if (act_busy !== 1'b0) begin fails++; $display("[TB] FAIL reset.mid_busy got %b want 0", act_busy); end
    checks++; if (act_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset.mid_ready got %b want 0", act_ready); end
    tick(x);
    rst_n = 1'b1;
    tick(x);
    checks++; if (act_y !== 8'h00)  begin fails++; $display("[TB] FAIL reset.after_y got %h want 00", act_y); end
    checks++; if (act_busy !== 1'b0) begin fails++; $display("[TB] FAIL reset.after_busy got %b want 0", act_busy); end
    checks++; if (act_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset.after_ready got %b want 1", act_ready); end
  endtask

  task automatic test_single();
    logic x;
    int   n20, ndone;
    n20 = 0; ndone = 0;
    for (int c = 0; c < 8; c++) begin
      valid_tb = (c == 0); idx_tb = 3'd5;
      tick(x);
      checks++; if (act_y !== exp_y)       begin fails++; $display("[TB] FAIL single.y e=%0d got %h want %h", e, act_y, exp_y); end
      checks++; if (act_done !== exp_done) begin fails++; $display("[TB] FAIL single.done e=%0d got %b want %b", e, act_done, exp_done); end
      checks++; if (act_busy !== exp_busy) begin fails++; $display("[TB] FAIL single.busy e=%0d got %b want %b", e, act_busy, exp_busy); end
      if (act_y === 8'h20) n20++;
      if (act_done === 1'b1) ndone++;
    end
    valid_tb = 1'b0;
    checks++; if (n20 !== 4)   begin fails++; $display("[TB] FAIL single.len got %0d want 4", n20); end
    checks++; if (ndone !== 1) begin fails++; $display("[TB] FAIL single.ndone got %0d want 1", ndone); end
  endtask

  task automatic test_queue();
    logic x;
    int   n80, ndone;
    n80 = 0; ndone = 0;
    for (int c = 0; c < 14; c++) begin
      valid_tb = (c == 0 || c == 2);
      idx_tb   = (c == 0) ? 3'd2 : 3'd7;
      tick(x);
      checks++; if (act_y !== exp_y)          begin fails++; $display("[TB] FAIL queue.y e=%0d got %h want %h", e, act_y, exp_y); end
      checks++; if (act_done !== exp_done)    begin fails++; $display("[TB] FAIL queue.done e=%0d got %b want %b", e, act_done, exp_done); end
      checks++; if (act_busy !== exp_busy)    begin fails++; $display("[TB] FAIL queue.busy e=%0d got %b want %b", e, act_busy, exp_busy); end
      checks++; if (act_ready !== model_ready()) begin fails++; $display("[TB] FAIL queue.ready e=%0d got %b want %b", e, act_ready, model_ready()); end
      if (act_y === 8'h80) n80++;
      if (act_done === 1'b1) ndone++;
    end
    valid_tb = 1'b0;
    checks++; if (n80 !== 4)   begin fails++; $display("[TB] FAIL queue.len80 got %0d want 4", n80); end
    checks++; if (ndone !== 2) begin fails++; $display("[TB] FAIL queue.ndone got %0d want 2", ndone); end
  endtask

  task automatic test_abort();
    logic x;
    logic saw_done, saw_02;
    saw_done = 1'b0; saw_02 = 1'b0;
    valid_tb = 1'b1; idx_tb = 3'd6; tick(x);
    idx_tb = 3'd1; tick(x);
    valid_tb = 1'b0; en_tb = 1'b0;
    tick(x);
    checks++; if (act_y !== 8'h00)   begin fails++; $display("[TB] FAIL abort.y got %h want 00", act_y); end
    checks++; if (act_ready !== 1'b0) begin fails++; $display("[TB] FAIL abort.ready got %b want 0", act_ready); end
    en_tb = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick(x);
      checks++; if (act_y !== exp_y)       begin fails++; $display("[TB] FAIL abort.y_after e=%0d got %h want %h", e, act_y, exp_y); end
      checks++; if (act_busy !== exp_busy) begin fails++; $display("[TB] FAIL abort.busy e=%0d got %b want %b", e, act_busy, exp_busy); end
      if (act_done === 1'b1) saw_done = 1'b1;
      if (act_y === 8'h02) saw_02 = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin fails++; $display("[TB] FAIL abort.done_seen got %b want 0", saw_done); end
    checks++; if (saw_02 !== 1'b0)   begin fails++; $display("[TB] FAIL abort.idx1_seen got %b want 0", saw_02); end
  endtask

  task automatic test_sweep();
    logic x;
    int   next_i, b;
    int   hold[8];
    int   order[$];
    logic [7:0] prev_y;
    next_i = 0; prev_y = 8'h00;
    foreach (hold[i]) hold[i] = 0;
    for (int c = 0; c < 80; c++) begin
      valid_tb = (next_i < 8);
      idx_tb   = 3'(next_i);
      tick(x);
      if (x) next_i++;
      checks++; if (act_y !== exp_y)       begin fails++; $display("[TB] FAIL sweep.y e=%0d got %h want %h", e, act_y, exp_y); end
      checks++; if (act_done !== exp_done) begin fails++; $display("[TB] FAIL sweep.done e=%0d got %b want %b", e, act_done, exp_done); end
      checks++; if (!$onehot0(act_y))      begin fails++; $display("[TB] FAIL sweep.onehot e=%0d got %h want onehot0", e, act_y); end
      if (act_y !== 8'h00) begin
        b = 0;
        for (int j = 0; j < 8; j++) if (act_y[j]) b = j;
        hold[b]++;
        if (act_y !== prev_y) order.push_back(b);
      end
      prev_y = act_y;
    end
    valid_tb = 1'b0;
    checks++; if (next_i !== 8) begin fails++; $display("[TB] FAIL sweep.accepted got %0d want 8", next_i); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (hold[i] !== PL) begin fails++; $display("[TB] FAIL sweep.hold%0d got %0d want %0d", i, hold[i], PL); end
    end
    checks++; if (order.size() !== 8) begin fails++; $display("[TB] FAIL sweep.npulses got %0d want 8", order.size()); end
    foreach (order[i]) begin
      checks++; if (order[i] !== i) begin fails++; $display("[TB] FAIL sweep.order%0d got %0d want %0d", i, order[i], i); end
    end
  endtask

  task automatic test_gap0();
    logic x;
    logic seen;
    logic [7:0] prev_y;
    seen = 1'b0; prev_y = 8'h00;
    for (int c = 0; c < 12; c++) begin
      valid_tb = (c < 2);
      idx_tb   = (c == 0) ? 3'd0 : 3'd1;
      tick(x);
      checks++; if (act_y !== exp_y)       begin fails++; $display("[TB] FAIL gap0.y e=%0d got %h want %h", e, act_y, exp_y); end
      checks++; if (act_done !== exp_done) begin fails++; $display("[TB] FAIL gap0.done e=%0d got %b want %b", e, act_done, exp_done); end
      checks++; if (act_busy !== exp_busy) begin fails++; $display("[TB] FAIL gap0.busy e=%0d got %b want %b", e, act_busy, exp_busy); end
      if (prev_y === 8'h01 && act_y !== 8'h01) begin
        seen = 1'b1;
        checks++; if (act_y !== 8'h02)   begin fails++; $display("[TB] FAIL gap0.next got %h want 02", act_y); end
        checks++; if (act_done !== 1'b1) begin fails++; $display("[TB] FAIL gap0.done_at_02 got %b want 1", act_done); end
      end
      prev_y = act_y;
    end
    valid_tb = 1'b0;
    checks++; if (seen !== 1'b1) begin fails++; $display("[TB] FAIL gap0.transition got %b want 1", seen); end
  endtask

  task automatic test_random(input int n);
    logic x;
    for (int c = 0; c < n; c++) begin
      en_tb    = ($urandom_range(0, 19) != 0);
      valid_tb = 1'($urandom_range(0, 1));
      idx_tb   = 3'($urandom_range(0, 7));
      tick(x);
      checks++; if (act_y !== exp_y)       begin fails++; $display("[TB] FAIL random.y e=%0d got %h want %h", e, act_y, exp_y); end
      checks++; if (act_done !== exp_done) begin fails++; $display("[TB] FAIL random.done e=%0d got %b want %b", e, act_done, exp_done); end
      checks++; if (act_busy !== exp_busy) begin fails++; $display("[TB] FAIL random.busy e=%0d got %b want %b", e, act_busy, exp_busy); end
      checks++; if (act_ready !== model_ready()) begin fails++; $display("[TB] FAIL random.ready e=%0d got %b want %b", e, act_ready, model_ready()); end
    end
    en_tb = 1'b1; valid_tb = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired got timeout want completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    $display("[TB] start");
    test_reset();
    test_single();
    test_queue();
    test_abort();
    test_sweep();
    test_random(300);
    select_dut(1'b1);
    test_gap0();
    test_random(300);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
